// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the MMIO UART transmitter:
// register offsets, STATUS bit positions, FSM encodings.
package mmio_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with flush; a push and pop in the same
// cycle read the old head before the new entry lands.
module mmio_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem[rd_q];

    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && !flush && (!full || pop_ok);
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + AW'(1);
            if (pop_ok)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= push_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: register decode, TX FIFO,
// 8N1 serialiser with programmable baud divisor.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] i_mmio_addr,
    input  logic [31:0] i_mmio_data,
    input  logic [3:0]  i_mmio_mask,
    input  logic        i_mmio_wren,
    output logic [31:0] o_mmio_data,
    output logic        o_tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   div_q, div_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [15:0]   baud_q, baud_d;
    logic          enable_q, enable_d;
    logic          ovf_q, ovf_d;

    logic          wr_txdata, wr_status, wr_baud, wr_ctrl;
    logic          push, pop, flush;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic [3:0]    cnt_field;
    logic          bit_end, can_pop;
    logic          unused_bits;

    assign unused_bits = ^{i_mmio_addr[29:2], i_mmio_data[31:16],
                           i_mmio_mask[3:2]};

    always_comb begin
        wr_txdata = i_mmio_wren && (i_mmio_addr[1:0] == REG_TXDATA);
        wr_status = i_mmio_wren && (i_mmio_addr[1:0] == REG_STATUS);
        wr_baud   = i_mmio_wren && (i_mmio_addr[1:0] == REG_BAUDDIV);
        wr_ctrl   = i_mmio_wren && (i_mmio_addr[1:0] == REG_CTRL);
        push      = wr_txdata && i_mmio_mask[0];
        flush     = wr_ctrl && i_mmio_mask[0] && i_mmio_data[1];
    end

    always_comb begin
        baud_d   = baud_q;
        enable_d = enable_q;
        ovf_d    = ovf_q;
        if (wr_baud && i_mmio_mask[0]) baud_d[7:0]  = i_mmio_data[7:0];
        if (wr_baud && i_mmio_mask[1]) baud_d[15:8] = i_mmio_data[15:8];
        if (wr_ctrl && i_mmio_mask[0]) enable_d = i_mmio_data[0];
        if (wr_status && i_mmio_mask[0] && i_mmio_data[3]) ovf_d = 1'b0;
        // a dropped push outranks a same-cycle clear
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    mmio_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (i_mmio_data[7:0]),
        .pop       (pop),
        .flush     (flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        bit_end = (cnt_q == 16'd0);
        can_pop = enable_q && !fifo_empty;
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: if (can_pop) begin
                pop     = 1'b1;
                state_d = S_START;
            end
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA:  if (bit_end && idx_q == 3'd7) state_d = S_STOP;
            S_STOP: if (bit_end) begin
                pop     = can_pop;
                state_d = can_pop ? S_START : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (pop) begin
            shift_d = fifo_head;
            div_d   = eff_div(baud_q);
            cnt_d   = eff_div(baud_q) - 16'd1;
            idx_d   = 3'd0;
            tx_d    = 1'b0;
        end else if (state_q == S_IDLE) begin
            tx_d = 1'b1;
        end else if (!bit_end) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            cnt_d = div_q - 16'd1;
            unique case (state_q)
                S_START: begin
                    idx_d = 3'd0;
                    tx_d  = shift_q[0];
                end
                S_DATA: if (idx_q == 3'd7) begin
                    tx_d = 1'b1;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end
                default: tx_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            div_q    <= eff_div(DEFAULT_DIV);
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            baud_q   <= DEFAULT_DIV;
            enable_q <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            baud_q   <= baud_d;
            enable_q <= enable_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_tx = tx_q;

    always_comb begin
        cnt_field   = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
        o_mmio_data = '0;
        unique case (i_mmio_addr[1:0])
            REG_STATUS: begin
                o_mmio_data[ST_FULL]  = fifo_full;
                o_mmio_data[ST_EMPTY] = fifo_empty;
                o_mmio_data[ST_BUSY]  = (state_q != S_IDLE);
                o_mmio_data[ST_OVF]   = ovf_q;
                o_mmio_data[ST_CNT_LSB +: 4] = cnt_field;
            end
            REG_BAUDDIV: o_mmio_data[15:0] = baud_q;
            REG_CTRL:    o_mmio_data[0]    = enable_q;
            default:     o_mmio_data       = '0;
        endcase
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter peripheral: the responder end of the CPU's MMIO port. It decodes word-addressed MMIO writes and reads from the crossbar's MMIO region, buffers bytes in a small TX FIFO, and serialises them on `o_tx` as 8N1 frames at a programmable baud divisor. It sits beside the CPU top-level, with its bus ports wired directly to the top-level MMIO outputs and input.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `DEFAULT_DIV`, 16'd434: reset value of BAUDDIV, in clock cycles per bit.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `i_mmio_addr`  in  30  word address; only `[1:0]` decoded, upper bits ignored (region select done upstream).
- `i_mmio_data`  in  32  write data.
- `i_mmio_mask`  in  4  byte enables for writes.
- `i_mmio_wren`  in  1  write strobe; a write completes in one cycle with no back-pressure.
- `o_mmio_data`  out  32  read data; combinational from `i_mmio_addr` and registered state.
- `o_tx`  out  1  serial line; idle high.

## Operation
- Register map (word offset = `addr[1:0]`):
  - 0 TXDATA: write with `mask[0]` pushes `data[7:0]`; reads 0.
  - 1 STATUS: read-only except W1C. Bit 0 full, bit 1 empty, bit 2 busy (FSM ≠ IDLE), bit 3 overflow (sticky), bits `[7:4]` FIFO count (saturating field), other bits 0. A write with `mask[0]` and `data[3]=1` clears overflow.
  - 2 BAUDDIV: `[15:0]`, R/W per byte mask (`mask[1:0]`); upper bits read 0. A value of 0 is treated as 1.
  - 3 CTRL: bit 0 enable (R/W, `mask[0]`). Writing bit 1 = 1 flushes the FIFO; bit 1 always reads 0.
- Reads have no side effects, because the bus has no read strobe.
- Push when full is dropped and sets overflow, unless a pop occurs in the same cycle; in that case the push is accepted.
- TX FSM states are IDLE, START, DATA, STOP.
  - IDLE → START: when enable=1 and FIFO non-empty. Pop the head into the shift register and latch BAUDDIV into the bit-period register.
  - START: `o_tx`=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each, tracked by a 3-bit index.
  - STOP: `o_tx`=1 for DIV cycles. At the end of STOP:
    - if enable && non-empty, pop and go straight to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- A frame is exactly 10×DIV cycles.
- Changing BAUDDIV mid-frame affects only the next frame.
- Clearing enable mid-frame: the current frame completes; no further pops.
- Flush: empties the FIFO (count=0) in one cycle and does not abort the frame in flight. A flush and a push in the same cycle leave the FIFO empty.
- Reset mid-frame: line returns high on the next edge; the frame is abandoned.

## Timing
- Reset values:
  - `o_tx`=1, FSM IDLE, FIFO empty, overflow=0;
  - BAUDDIV=`DEFAULT_DIV`, enable=1;
  - `o_mmio_data` reflects the reset state (STATUS reads 0x2).
- A write on edge E0 is visible in STATUS after E0, in the same-cycle read.
- Start-bit latency: if idle and enabled, the pop happens on edge E1 and `o_tx` goes low from E1. This is one cycle after the write edge.
- `o_tx` is driven directly from a flop; no combinational path from bus to line.
- Baud counter counts DIV−1 down to 0; a bit advances when the counter is 0.

## Structure
- Shared header `uart_defs.vh`:
  - register offsets;
  - STATUS bit positions;
  - FSM state encodings (2-bit localparams);
  - frame length constant (10).
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`):
  - ports push, pop, flush, full, empty, count, head;
  - read-before-write semantics on simultaneous push/pop.
- The top module holds the register decode, TX FSM, baud counter and shift register.

## Test plan
- Reset, then read STATUS → 0x00000002, BAUDDIV → 434, CTRL → 1; `o_tx`=1.
- DIV=4, write 0xA5 → `o_tx` low from the next edge for 4 cycles. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; busy=1 for all 40 cycles.
- DIV=2, enable=0, push 9 bytes (0x00–0x08) → full=1, count field=8, overflow=1. Clear overflow with W1C → bit 3 = 0.
- With enable=0, push 3 bytes. Set enable=1 → three back-to-back 20-cycle frames with no idle gap; empty=1 after the first pop of the third byte; busy drops after cycle 60.
- With a frame in flight and 2 bytes queued, write CTRL=0x3 (flush) → current frame completes, then IDLE; count=0.
- Assert `rst` mid-DATA bit → `o_tx`=1 on the next edge, registers return to reset values, and the following TXDATA write transmits normally.
